// File: rtl/bin_to_tern_64_pkg.sv
// Shared constants and FSM state type for the binary-to-ternary converter.
package bin2tern_pkg;

    localparam int DATA_W     = 64;  // dividend width; only 64 is supported
    localparam int MAX_DIGITS = 41;  // base-3 digits needed for 2^64-1
    localparam int IDX_W      = 6;   // width of the digit position counter

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_tern_64_div.sv
// div_64_3: combinational divide-by-3 core.
// X is a 64-bit dividend, Q the 63-bit quotient, R the remainder (0..2).
// The quotient always fits in 63 bits because (2^64-1)/3 < 2^63.
module div_64_3 (
    input  logic [63:0] X,
    output logic [62:0] Q,
    output logic [1:0]  R
);

    // Restoring long division, one dividend bit per step, MSB first.
    always_comb begin
        logic [2:0] w_t;
        logic [1:0] w_rem;
        // NOTE: blocking assignments here because each loop step must see the
        // remainder produced by the previous step within the same evaluation.
        Q     = '0;
        // The top bit alone can never reach 3, so it only seeds the remainder.
        w_rem = {1'b0, X[63]};
        for (int i = 62; i >= 0; i--) begin
            w_t = {w_rem, X[i]};
            if (w_t >= 3'd3) begin
                Q[i] = 1'b1;
                w_t  = w_t - 3'd3;
            end
            w_rem = w_t[1:0];
        end
        R = w_rem;
    end

endmodule

// File: rtl/bin_to_tern_64.sv
// bin_to_tern_64: streams the base-3 digits of a 64-bit unsigned value,
// least-significant digit first, one digit per dig_valid/dig_ready handshake.
// Build option: define BIN2TERN_FULLWIDTH_EN to always emit all 41 digits
// (leading zeros included); by default leading zeros are suppressed.
module bin_to_tern_64
    import bin2tern_pkg::*;
#(
    parameter int DATA_W     = bin2tern_pkg::DATA_W,
    parameter int MAX_DIGITS = bin2tern_pkg::MAX_DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic [1:0]        dig,
    output logic [IDX_W-1:0]  dig_idx,
    output logic              dig_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DIGITS - 1);

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_wr, w_wr_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;

    logic [DATA_W-2:0]  w_q;
    logic [1:0]         w_r;
    logic               w_run;
    logic               w_last;
    logic               w_dig_hs;
    logic               w_accept;

    // Single divide core on the working register supplies digit and quotient.
    div_64_3 u_div (
        .X (r_wr),
        .Q (w_q),
        .R (w_r)
    );

    assign w_run = (r_state == RUN);

`ifdef BIN2TERN_FULLWIDTH_EN
    assign w_last = (r_idx == LAST_IDX);
`else
    assign w_last = (r_idx == LAST_IDX) || (w_q == '0);
`endif

    // Digit outputs are forced to zero outside RUN so IDLE shows a clean bus.
    assign dig_valid = w_run;
    assign busy      = w_run;
    assign dig       = w_run ? w_r   : 2'd0;
    assign dig_idx   = w_run ? r_idx : '0;
    assign dig_last  = w_run & w_last;

    assign w_dig_hs = dig_valid & dig_ready;
    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready = rst_n & ((r_state == IDLE) | (w_dig_hs & dig_last));
    assign w_accept = in_valid & in_ready;

    // Next-state logic: new value load takes priority over finishing the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr;
        w_idx_nxt   = r_idx;
        if (w_accept) begin
            w_state_nxt = RUN;
            w_wr_nxt    = in_data;
            w_idx_nxt   = '0;
        end else if (w_dig_hs && dig_last) begin
            w_state_nxt = IDLE;
        end else if (w_dig_hs) begin
            w_wr_nxt    = {1'b0, w_q};
            w_idx_nxt   = r_idx + 1'b1;
        end
    end

    // State, working register and digit index; all hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register is reset here, including the 64-bit working
        // register, so an aborted conversion leaves nothing behind.
        if (!rst_n) begin
            r_state <= IDLE;
            r_wr    <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr    <= w_wr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_bin_to_tern_64.sv
// Self-checking bench for bin_to_tern_64: directed values with hand-derived
// digit sequences, stall stability, back-to-back loading and mid-run reset.
module tb_bin_to_tern_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        dig_valid;
    logic        dig_ready;
    logic [1:0]  dig;
    logic [5:0]  dig_idx;
    logic        dig_last;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] got_d[$];
    logic [1:0] exp_d[$];

    localparam logic [63:0] P3_40 = 64'd12157665459056928801;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    bin_to_tern_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig       (dig),
        .dig_idx   (dig_idx),
        .dig_last  (dig_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference digit list built with the bench's own arithmetic.
    task automatic model(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        exp_d = {};
`ifdef BIN2TERN_FULLWIDTH_EN
        for (int k = 0; k < 41; k++) begin
            exp_d.push_back(2'(x % 64'd3));
            x = x / 64'd3;
        end
`else
        do begin
            exp_d.push_back(2'(x % 64'd3));
            x = x / 64'd3;
        end while (x != 64'd0 && exp_d.size() < 41);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one value and drain all its digits, optionally with random stalls.
    task automatic run_value(input logic [63:0] v, input bit stall);
        int          k;
        int          cyc;
        logic [63:0] recomp;
        logic [63:0] pw;
        logic [1:0]  s_dig;
        logic [5:0]  s_idx;
        logic        s_last;
        model(v);
        got_d = {};
        in_data  = v;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) check("accept_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
        k = 0;
        cyc = 0;
        recomp = '0;
        pw = 64'd1;
        while (k < exp_d.size() && cyc < 400) begin
            cyc++;
            dig_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("dig_valid", dig_valid, 1);
            s_dig  = dig;
            s_idx  = dig_idx;
            s_last = dig_last;
            if (dig_ready) begin
                check("dig", dig, exp_d[k]);
                check("dig_idx", dig_idx, k);
                check("dig_last", dig_last, k == exp_d.size() - 1);
                if (k == exp_d.size() - 1) check("in_ready_last", in_ready, 1);
                got_d.push_back(dig);
                recomp = recomp + 64'(dig) * pw;
                pw = pw * 64'd3;
                k++;
                tick();
            end else begin
                tick();
                check("stall_dig", dig, s_dig);
                check("stall_idx", dig_idx, s_idx);
                check("stall_last", dig_last, s_last);
            end
        end
        if (k < exp_d.size()) check("drain_timeout", 1, 0);
        dig_ready = 1'b0;
        #1;
        check("idle_after", dig_valid, 0);
        check("recompose", recomp, v);
    endtask

    initial begin
        logic [1:0] stream[$];
        logic [1:0] seq_ready1[$];
        int         k;
        int         cyc;
        bit         second_loaded;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        dig_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_dig_valid", dig_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_dig_valid", dig_valid, 0);
        check("rel_dig", dig, 0);
        check("rel_idx", dig_idx, 0);
        check("rel_last", dig_last, 0);
        check("rel_busy", busy, 0);
        @(negedge clk);

        // 5 = 12 in base 3 -> digits 2, 1
        run_value(64'd5, 1'b0);
`ifndef BIN2TERN_FULLWIDTH_EN
        check("five_count", got_d.size(), 2);
        check("five_d0", got_d[0], 2);
        check("five_d1", got_d[1], 1);
`endif

        // Zero: a single 0 digit, or 41 zeros in full-width mode.
        run_value(64'd0, 1'b0);
`ifdef BIN2TERN_FULLWIDTH_EN
        check("zero_count", got_d.size(), 41);
`else
        check("zero_count", got_d.size(), 1);
`endif
        check("zero_d0", got_d[0], 0);

        // 3^40: 40 zeros then a 1 at index 40.
        run_value(P3_40, 1'b0);
        check("p340_count", got_d.size(), 41);
        check("p340_d39", got_d[39], 0);
        check("p340_d40", got_d[40], 1);

        // 2^64-1: 41 digits, top digit 1.
        run_value(ALL1, 1'b0);
        seq_ready1 = got_d;
        check("all1_count", got_d.size(), 41);
        check("all1_d40", got_d[40], 1);

        // Same value with random consumer stalls must give the same sequence.
        run_value(ALL1, 1'b1);
        for (int i = 0; i < 41; i++) check("stall_seq", got_d[i], seq_ready1[i]);
        run_value(64'd1234567890123, 1'b1);

        // Back-to-back: 5 then 7 with in_valid held, no bubble.
        model(64'd5);
        stream = exp_d;
        model(64'd7);
        stream = {stream, exp_d};
        in_data   = 64'd5;
        in_valid  = 1'b1;
        dig_ready = 1'b1;
        tick();
        in_data = 64'd7;
        second_loaded = 1'b0;
        got_d = {};
        k = 0;
        cyc = 0;
        while (k < stream.size() && cyc < 200) begin
            cyc++;
            check("b2b_valid", dig_valid, 1);
            check("b2b_dig", dig, stream[k]);
            got_d.push_back(dig);
            if (dig_last && !second_loaded) begin
                check("b2b_in_ready", in_ready, 1);
                second_loaded = 1'b1;
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
            k++;
        end
        if (k < stream.size()) check("b2b_timeout", 1, 0);
        dig_ready = 1'b0;
        #1;
        check("b2b_idle", dig_valid, 0);
`ifndef BIN2TERN_FULLWIDTH_EN
        check("b2b_n", got_d.size(), 4);
        check("b2b_0", got_d[0], 2);
        check("b2b_1", got_d[1], 1);
        check("b2b_2", got_d[2], 1);
        check("b2b_3", got_d[3], 2);
`endif

        // Reset during RUN at digit index 3 of 2^64-1.
        @(negedge clk);
        in_data  = ALL1;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        dig_ready = 1'b1;
        cyc = 0;
        while (dig_idx != 6'd3 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rst_at_idx3", dig_idx, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", dig_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        tick();
        tick();
        check("midrst_valid_hold", dig_valid, 0);
        rst_n = 1'b1;
        #1;
        check("postrst_valid", dig_valid, 0);
        check("postrst_in_ready", in_ready, 1);
        tick();
        check("postrst_valid_clk", dig_valid, 0);
        dig_ready = 1'b0;
        @(negedge clk);
        run_value(64'd7, 1'b0);
        check("post_d0", got_d[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_tern_64.md
BIN_TO_TERN_64 -- requirements
Module: bin_to_tern_64

Interface
REQ-001 Parameter: DATA_W, default 64, dividend width; only 64 is supported.
REQ-002 Parameter: MAX_DIGITS, default 41, base-3 digits needed for 2^64-1.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  64  unsigned binary value to convert.
REQ-008 dig_valid  output  1  dig, dig_idx and dig_last are valid.
REQ-009 dig_ready  input  1  consumer accepts the digit this cycle.
REQ-010 dig  output  2  base-3 digit in the range 0..2; value 3 is never produced.
REQ-011 dig_idx  output  6  digit position, 0 = least significant.
REQ-012 dig_last  output  1  marks the final digit of the current value.
REQ-013 busy  output  1  a conversion is in progress (state RUN).

Function
REQ-014 The block shall emit digits least-significant first by repeated division by 3, one digit per dig handshake.
REQ-015 FSM states: IDLE and RUN; IDLE->RUN on in_valid&in_ready; RUN->IDLE on a handshake with dig_last=1 and no new input in that cycle; RUN->RUN on that same handshake when in_valid=1 (new value loaded).
REQ-016 in_ready shall be (state==IDLE) | (dig_valid & dig_ready & dig_last), giving back-to-back conversions with no bubble.
REQ-017 On input acceptance: working register WR<=in_data, idx<=0, and dig_valid=1 from the next cycle (latency 1 cycle).
REQ-018 In RUN: dig=WR mod 3 and dig_last is computed combinationally from WR through the divide core; dig_idx=idx; dig_valid=1.
REQ-019 On a handshake without dig_last: WR<=WR/3 (63-bit quotient zero-extended to 64 bits), idx<=idx+1.
REQ-020 When dig_valid=1 and dig_ready=0, WR, idx, dig, dig_idx and dig_last shall hold stable.
REQ-021 dig_last=1 when idx==MAX_DIGITS-1; the additional termination rule is set by REQ-026/027.
REQ-022 in_data=0 shall produce exactly one digit: 0 with dig_idx 0.
REQ-023 idx shall never exceed 40; no wrap-around occurs.

Reset
REQ-024 While rst_n=0: state=IDLE, WR=0, idx=0, dig_valid=0, busy=0, in_ready=0; after release: in_ready=1 and all other outputs 0.
REQ-025 Reset asserted during RUN shall abort the conversion; no further digit of that value is emitted.

Configuration
REQ-026 Macro BIN2TERN_FULLWIDTH_EN defined: every conversion emits exactly 41 digits, including leading zeros; dig_last only at idx 40.
REQ-027 Macro BIN2TERN_FULLWIDTH_EN undefined: dig_last=1 also when WR/3==0, which suppresses leading zeros.

Structure
REQ-028 Package bin2tern_pkg shall hold DATA_W, MAX_DIGITS, IDX_W=6 and the IDLE/RUN state enum.
REQ-029 Sub-module: the existing combinational core div_64_3 (X[64], Q[63], R[2]) shall be instantiated once on WR; no other arithmetic divider is allowed.

Verification
REQ-030 in_data=5, dig_ready=1 -> digits 2 (idx0), then 1 (idx1, last); in_ready high in the cycle of the last handshake.
REQ-031 in_data=0 -> single digit 0, idx0, last; with BIN2TERN_FULLWIDTH_EN -> 41 zeros, last at idx40.
REQ-032 in_data=12157665459056928801 (3^40) -> 40 zeros, then digit 1 at idx40 with last; in_data=2^64-1 -> 41 digits, idx40 digit=1, and recomposition equals the input.
REQ-033 Random dig_ready stalls -> outputs stable while stalled; the digit sequence is unchanged versus dig_ready=1.
REQ-034 Back-to-back inputs 5 then 7, in_valid held -> digits 2,1,1,2 with no idle cycle between the values.
REQ-035 rst_n pulsed low at idx 3 of 2^64-1 -> dig_valid=0 during reset and after release; the next input converts correctly from idx0.
